car_blink_decoder: RTL
======================

# car_blink_decoder

Receive-side decoder for the turn-signal LED lines driven by the car switch/blink controller. Samples `led1_in`/`led2_in`, classifies each line per measurement window as steady-off, blinking or faulty, and reconstructs the 2-bit switch code that produced the pattern. Used for self-check, loopback and the dashboard monitor.

## Interface
- `WINDOW`, 64: measurement window length in `clkout` cycles; must be at least 4.
- `CNT_W`, 8: width of the window and edge counters; 2**CNT_W must be greater than `WINDOW`.
- `MIN_EDGES`, 2: minimum edges in one window for a line to classify as blinking; must be at least 2.
- `clkout` input 1: block clock, rising edge; must be at least 4x the LED toggle rate.
- `rst_n` input 1: reset, asynchronous, active-low.
- `led1_in` input 1: LED1 line, asynchronous to `clkout`. 1 = off, 0 = on.
- `led2_in` input 1: LED2 line, asynchronous to `clkout`.
- `sw_dec` output 2: decoded switch code. Bit0 = LED1 blinking, bit1 = LED2 blinking.
- `dec_valid` output 1: one-cycle pulse at the end of every evaluated window.
- `dec_change` output 1: one-cycle pulse, coincident with `dec_valid`, when `sw_dec` changes value.
- `fault` output 2: per-line fault flags, held level. Bit0 = LED1, bit1 = LED2.

## Operation
- Synchronizer: each line passes through a 2-flop synchronizer, then a third delay flop.
  - An edge is a mismatch between sync stage 2 and the delay flop.
  - Both rising and falling edges count.
- Window counter `wcnt` runs 0..WINDOW-1 and wraps.
  - The last window cycle is `wcnt==WINDOW-1`; this is the evaluate cycle.
- Per-line edge counter.
  - Increments on each edge and saturates at 2**CNT_W-1.
  - In the evaluate cycle it loads 1 if an edge occurs in that same cycle, otherwise 0. That edge belongs to the next window.
- Per-line low-seen flag.
  - Set whenever sync stage 2 is 0.
  - Cleared in the evaluate cycle, same load rule as the edge counter.
- Per-line classification at evaluate, using this window's counts including the evaluate cycle itself:
  - BLINK: edges >= MIN_EDGES.
  - OFF: edges == 0 and low-seen == 0.
  - FAULT: anything else. Covers stuck-on (edges 0, low seen) and too few edges (1..MIN_EDGES-1).
- State machine, two states:
  - WARMUP, entered on reset. Counters run but no outputs update. Moves to MEASURE at the end of the first evaluate cycle.
  - MEASURE: every evaluate cycle updates the outputs. No exit except reset.
- Output update at MEASURE evaluate, all outputs registered:
  - For each line classified OFF or BLINK, the matching `sw_dec` bit is 0 or 1, and the matching `fault` bit is cleared.
  - For a FAULT line, the `sw_dec` bit holds its previous value and the `fault` bit is set.
  - `dec_valid` is 1 for one cycle.
  - `dec_change` is 1 when the new `sw_dec` differs from the old one.
- Reset values: `sw_dec`=00, `dec_valid`=0, `dec_change`=0, `fault`=00. Internal counters, flags and synchronizer flops reset to idle-line state: sync flops 1, counters 0, flags 0.
- Asserting reset mid-window aborts the window. The block returns to WARMUP and the partial counts are discarded.

## Timing
- The `dec_valid` pulse appears in the cycle after the evaluate cycle, when the output registers update.
- First `dec_valid` after reset release: cycle 2*WINDOW, counting the first clock edge after release as cycle 1.
- Subsequent pulses follow every WINDOW cycles.
- Input-to-count latency: 3 cycles (2 sync flops plus the edge compare register).
  - Edges arriving in the last 3 cycles of a window are counted in the next window.
- Decode latency after a pattern change: at most 2 windows plus 3 cycles.
  - A window that straddles the change may classify as FAULT. In that case `sw_dec` holds and `fault` pulses for that window.
- `sw_dec` and `fault` change only on `dec_valid` cycles.

## Test plan
1. Both lines held 1 from reset, WINDOW=64:
   - Required: first `dec_valid` at cycle 128 with `sw_dec`=00, `fault`=00, `dec_change`=0.
   - Thereafter: a `dec_valid` pulse every 64 cycles.
2. `led1_in` toggles every 8 cycles, `led2_in` held 1:
   - Required: from the second MEASURE window on, `sw_dec`=01, `fault`=00.
   - `dec_change`=1 exactly once, at the transition from 00.
3. Both lines toggle every 8 cycles, then switch to `led1_in` only:
   - Required: `sw_dec`=11.
   - After the switch, `sw_dec` goes to 01 within 2 windows.
   - `dec_change` pulses on each transition.
4. `led2_in` held 0 (stuck on):
   - Required: `fault`=10.
   - `sw_dec[1]` keeps its previous value.
   - Release the line to 1: the next full window gives `fault`=00.
5. `led1_in` gets a single pulse (2 edges) landing in the last 2 cycles of a window:
   - Required: both edges count in the next window, giving `sw_dec[0]`=1 there.
   - The earlier window reads OFF.
6. Assert `rst_n` low mid-window while decoding 11:
   - Required: outputs read 00 asynchronously.
   - After release, no `dec_valid` until cycle 128.

Source files
------------

// File: rtl/car_blink_decoder.sv
// car_blink_decoder: classifies each turn-signal LED line per window and rebuilds the switch code
module car_blink_decoder #(
    parameter int WINDOW    = 64,
    parameter int CNT_W     = 8,
    parameter int MIN_EDGES = 2
) (
    input  logic       clkout,
    input  logic       rst_n,
    input  logic       led1_in,
    input  logic       led2_in,
    output logic [1:0] sw_dec,
    output logic       dec_valid,
    output logic       dec_change,
    output logic [1:0] fault
);
    typedef enum logic {WARMUP, MEASURE} state_t;

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] C_MIN  = CNT_W'(MIN_EDGES);
    localparam logic [CNT_W-1:0] C_MAX  = '1;

    state_t                  r_state, w_state_nxt;
    logic [1:0]              r_s1, r_s2, r_d, r_low;
    logic [CNT_W-1:0]        r_wcnt;
    logic [1:0][CNT_W-1:0]   r_ecnt, w_ecnt_now;
    logic [1:0]              w_edge, w_low_now, w_blink, w_off;
    logic                    w_eval;
    logic [1:0]              w_sw_nxt, w_fault_nxt;
    logic                    w_valid_nxt, w_change_nxt;

    assign w_edge    = r_s2 ^ r_d;
    assign w_low_now = r_low | ~r_s2;
    assign w_eval    = (r_wcnt == C_LAST);

    // two-flop synchronizer plus delay flop; idle line level is 1
    always_ff @(posedge clkout or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 2'b11;
            r_s2 <= 2'b11;
            r_d  <= 2'b11;
        end else begin
            r_s1 <= {led2_in, led1_in};
            r_s2 <= r_s1;
            r_d  <= r_s2;
        end
    end

    // window counter, wraps after the evaluate cycle
    always_ff @(posedge clkout or negedge rst_n) begin
        if (!rst_n) r_wcnt <= '0;
        else        r_wcnt <= w_eval ? '0 : r_wcnt + CNT_W'(1);
    end

    // per-line counts including the current cycle, and their classification
    always_comb begin
        w_ecnt_now = r_ecnt;
        w_blink    = '0;
        w_off      = '0;
        for (int i = 0; i < 2; i++) begin
            w_ecnt_now[i] = (w_edge[i] && r_ecnt[i] != C_MAX) ? r_ecnt[i] + CNT_W'(1) : r_ecnt[i];
            w_blink[i]    = (w_ecnt_now[i] >= C_MIN);
            w_off[i]      = (w_ecnt_now[i] == '0) && !w_low_now[i];
        end
    end

    // edge counters and low-seen flags; an evaluate-cycle event seeds the next window
    always_ff @(posedge clkout or negedge rst_n) begin
        if (!rst_n) begin
            r_ecnt <= '0;
            r_low  <= '0;
        end else begin
            for (int i = 0; i < 2; i++)
                r_ecnt[i] <= w_eval ? {{(CNT_W-1){1'b0}}, w_edge[i]} : w_ecnt_now[i];
            r_low <= w_eval ? ~r_s2 : w_low_now;
        end
    end

    // state register
    always_ff @(posedge clkout or negedge rst_n) begin
        if (!rst_n) r_state <= WARMUP;
        else        r_state <= w_state_nxt;
    end

    // next state and next output values; faulty lines keep their decoded bit
    always_comb begin
        w_state_nxt  = r_state;
        w_sw_nxt     = sw_dec;
        w_fault_nxt  = fault;
        w_valid_nxt  = 1'b0;
        w_change_nxt = 1'b0;
        if (w_eval) begin
            if (r_state == WARMUP) begin
                w_state_nxt = MEASURE;
            end else begin
                w_sw_nxt     = w_blink | (sw_dec & ~w_off);
                w_fault_nxt  = ~(w_blink | w_off);
                w_valid_nxt  = 1'b1;
                w_change_nxt = (w_sw_nxt != sw_dec);
            end
        end
    end

    // registered outputs
    always_ff @(posedge clkout or negedge rst_n) begin
        if (!rst_n) begin
            sw_dec     <= 2'b00;
            fault      <= 2'b00;
            dec_valid  <= 1'b0;
            dec_change <= 1'b0;
        end else begin
            sw_dec     <= w_sw_nxt;
            fault      <= w_fault_nxt;
            dec_valid  <= w_valid_nxt;
            dec_change <= w_change_nxt;
        end
    end
endmodule
